// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU instruction path and its program loader.
package cpu_pkg;

    localparam int unsigned INSTR_W = 22;
    localparam int unsigned ADDR_W  = 22;
    localparam int unsigned DEPTH   = 101;
    localparam int unsigned IDX_W   = $clog2(DEPTH + 1);
    localparam int unsigned LEN_W   = 16;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        B0,
        B1,
        B2,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    // Word index to byte address; the memory drops bits 1:0.
    function automatic logic [ADDR_W-1:0] word_to_byte_addr(input logic [IDX_W-1:0] idx);
        word_to_byte_addr = {{(ADDR_W - IDX_W - 2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_loader_packer.sv
// Packs three little-endian stream bytes into one instruction and flags a malformed top byte.
module instr_byte_packer
    import cpu_pkg::*;
(
    input  logic [7:0]         b0,
    input  logic [7:0]         b1,
    input  logic [7:0]         b2,
    output logic [INSTR_W-1:0] word,
    output logic               fmt_ok
);

    always_comb begin
        word   = {b2[5:0], b1, b0};
        fmt_ok = (b2[7:6] == 2'b00);
    end

endmodule

// File: rtl/instruction_loader.sv
// Byte-stream program loader: length header, then 3 bytes per instruction written into the
// instruction RAM one word at a time, with the CPU held until the image is complete.
module instruction_loader
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               we,
    output logic [ADDR_W-1:0]  waddr,
    output logic [INSTR_W-1:0] wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    loader_state_t      state;
    logic [IDX_W-1:0]   idx;
    logic [LEN_W-1:0]   len;
    logic [7:0]         b0;
    logic [7:0]         b1;

    logic               xfer;
    logic [LEN_W-1:0]   len_rx;
    logic [LEN_W-1:0]   idx_next;
    logic [INSTR_W-1:0] packed_word;
    logic               fmt_ok;

    instr_byte_packer u_packer (
        .b0     (b0),
        .b1     (b1),
        .b2     (in_data),
        .word   (packed_word),
        .fmt_ok (fmt_ok)
    );

    always_comb begin
        xfer     = in_valid & in_ready;
        len_rx   = {in_data, len[7:0]};
        idx_next = {{(LEN_W - IDX_W){1'b0}}, idx} + LEN_W'(1);
    end

    // in_ready is registered alongside the state so it is high exactly in LEN_*/B* states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            len      <= '0;
            b0       <= '0;
            b1       <= '0;
            in_ready <= 1'b0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state    <= LEN_LO;
                        idx      <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= in_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len <= len_rx;
                        if (len_rx == '0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else if (len_rx > LEN_W'(DEPTH)) begin
                            state    <= ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= B0;
                        end
                    end
                end
                B0: begin
                    if (xfer) begin
                        b0    <= in_data;
                        state <= B1;
                    end
                end
                B1: begin
                    if (xfer) begin
                        b1    <= in_data;
                        state <= B2;
                    end
                end
                B2: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (fmt_ok) begin
                            we    <= 1'b1;
                            waddr <= word_to_byte_addr(idx);
                            wdata <= packed_word;
                            state <= WRITE;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    idx <= idx + IDX_W'(1);
                    if (idx_next == len) begin
                        state    <= DONE;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state    <= B0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized self-checking bench for instruction_loader against a stream-level reference model.
module tb_instruction_loader;
    import cpu_pkg::*;

    localparam int LIMIT = 5000;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [INSTR_W-1:0] wdata;
    logic               cpu_hold;
    logic               done;
    logic               error;

    instruction_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]         stream[$];
    logic [ADDR_W-1:0]  exp_addr[$];
    logic [INSTR_W-1:0] exp_data[$];
    logic [INSTR_W-1:0] tb_mem[0:127];
    logic [INSTR_W-1:0] snap[0:127];
    bit                 exp_ok;
    bit                 exp_err;
    int                 last_xfer_cyc;
    int                 end_cyc;
    bit                 chk_spacing = 0;
    int                 last_we_cyc = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the next write the model predicts.
    always @(negedge clk) begin
        if (!rst && we) begin
            check_eq("we_expected", 32'(exp_addr.size() > 0), 1);
            if (exp_addr.size() > 0) begin
                check_eq("waddr", 32'(waddr), 32'(exp_addr.pop_front()));
                check_eq("wdata", 32'(wdata), 32'(exp_data.pop_front()));
            end
            tb_mem[waddr[8:2]] = wdata;
            if (chk_spacing && last_we_cyc >= 0) check_eq("we_spacing", cyc - last_we_cyc, 4);
            last_we_cyc = cyc;
        end
    end

    // Stream of n header, `words` instructions; triple bad_at carries a malformed top byte.
    task automatic gen_stream(input int n, input int words, input int bad_at);
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        for (int k = 0; k < words; k++) begin
            stream.push_back(8'($urandom));
            stream.push_back(8'($urandom));
            stream.push_back((k == bad_at) ? 8'hC0 : 8'($urandom & 32'h3F));
        end
    endtask

    // Reference: what a correct loader writes and how it ends, from the byte stream alone.
    task automatic build_expect();
        int n;
        exp_addr.delete();
        exp_data.delete();
        exp_ok  = 0;
        exp_err = 0;
        n = (stream.size() >= 2) ? int'({stream[1], stream[0]}) : 0;
        if (n == 0) begin
            exp_ok = 1;
        end else if (n > int'(DEPTH)) begin
            exp_err = 1;
        end else begin
            for (int k = 0; k < n; k++) begin
                if (3 * k + 4 >= stream.size()) return;
                if (stream[3 * k + 4][7:6] != 2'b00) begin
                    exp_err = 1;
                    return;
                end
                exp_addr.push_back(ADDR_W'(k * 4));
                exp_data.push_back({stream[3 * k + 4][5:0], stream[3 * k + 3], stream[3 * k + 2]});
            end
            exp_ok = 1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("start_hold", 32'(cpu_hold), 1);
        check_eq("start_ready", 32'(in_ready), 1);
        check_eq("start_clr", 32'({done, error}), 0);
    endtask

    task automatic run_load(input int gap_pct, input bit wait_end, input bit poke_start);
        int  i = 0;
        int  budget = 0;
        bit  will;
        last_xfer_cyc = cyc;
        while (budget < LIMIT) begin
            if (wait_end && (done || error)) break;
            if (!wait_end && i >= stream.size()) break;
            if (i < stream.size() && int'($urandom_range(99)) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = stream[i];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            start = poke_start && (i < stream.size()) && !done && !error &&
                    ($urandom_range(9) == 0);
            @(negedge clk);
            will = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (will) begin
                i++;
                last_xfer_cyc = cyc;
            end
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        end_cyc  = cyc;
        check_eq("load_bound", 32'(budget < LIMIT), 1);
    endtask

    task automatic end_checks(input string tag);
        check_eq({tag, "_done"}, 32'(done), 32'(exp_ok));
        check_eq({tag, "_error"}, 32'(error), 32'(exp_err));
        check_eq({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_ok));
        check_eq({tag, "_ready"}, 32'(in_ready), 0);
        check_eq({tag, "_pending"}, exp_addr.size(), 0);
        // Completed load: WRITE sits between the last transfer and DONE; otherwise immediate.
        check_eq({tag, "_latency"}, end_cyc - last_xfer_cyc,
                 (exp_ok && stream.size() > 2 && {stream[1], stream[0]} != 16'd0) ? 1 : 0);
    endtask

    task automatic load(input string tag, input int gap_pct, input bit poke_start);
        build_expect();
        do_start();
        run_load(gap_pct, 1, poke_start);
        repeat (2) @(posedge clk);
        #1;
        end_checks(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(in_ready), 0);
        check_eq({tag, "_we"}, 32'(we), 0);
        check_eq({tag, "_waddr"}, 32'(waddr), 0);
        check_eq({tag, "_wdata"}, 32'(wdata), 0);
        check_eq({tag, "_hold"}, 32'(cpu_hold), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_error"}, 32'(error), 0);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        stream = '{8'h01, 8'h00, 8'h88, 8'h08, 8'h26};
        load("one_word", 0, 0);

        gen_stream(8, 8, -1);
        chk_spacing = 1;
        last_we_cyc = -1;
        load("eight_b2b", 0, 0);
        chk_spacing = 0;

        // Same image whether the source is gap-free or bursty.
        n = 12 + int'($urandom_range(8));
        gen_stream(n, n, -1);
        load("img_ref", 0, 0);
        for (int k = 0; k < n; k++) snap[k] = tb_mem[k];
        for (int k = 0; k < 128; k++) tb_mem[k] = '0;
        load("img_gappy", 50, 1);
        for (int k = 0; k < n; k++) check_eq("img_match", 32'(tb_mem[k]), 32'(snap[k]));

        gen_stream(0, 0, -1);
        load("n_zero", 0, 0);

        gen_stream(102, 0, -1);
        load("n_over", 0, 0);

        gen_stream(int'(DEPTH), int'(DEPTH), -1);
        load("n_full", 30, 1);

        gen_stream(3, 3, 1);
        load("bad_b2", 20, 0);

        n = 1 + int'($urandom_range(15));
        gen_stream(n, n, -1);
        load("recover", 40, 1);

        // Abort after the second byte of word 1, then reload from index 0.
        gen_stream(3, 3, -1);
        while (stream.size() > 7) void'(stream.pop_back());
        build_expect();
        do_start();
        run_load(20, 0, 0);
        @(negedge clk);
        check_eq("pre_rst_pending", exp_addr.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        n = 2 + int'($urandom_range(6));
        gen_stream(n, n, -1);
        load("after_rst", 25, 0);

        for (int t = 0; t < 4; t++) begin
            n = 1 + int'($urandom_range(20));
            gen_stream(n, n, ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1);
            load("rand", int'($urandom_range(60)), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
